// File: rtl/control_pkg.sv
// control_pkg: shared types and constants for the instruction sequencer.
//   state_t      - sequencer T-state enumeration
//   AG_*         - bus agent indices into the OE/WE vectors
//   OP_*         - decoded opcodes (low nibble of the instruction)
//   ALU_*        - ALU operation codes
//   tstate_code  - 3-bit debug code for a state (HALT and PRG share 7;
//                  HALTED distinguishes them)
package control_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_F1,
        S_F2,
        S_F3,
        S_E1,
        S_E2,
        S_E3,
        S_HALT,
        S_PRG
    } state_t;

    localparam int AG_PC   = 0;
    localparam int AG_ACC  = 1;
    localparam int AG_BREG = 2;
    localparam int AG_MAR  = 3;
    localparam int AG_MEM  = 4;
    localparam int AG_OR   = 5;
    localparam int AG_IR   = 6;
    localparam int AG_ALU  = 7;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_OUT = 4'h5;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    function automatic logic [2:0] tstate_code(input state_t s);
        logic [2:0] code;
        case (s)
            S_IDLE:  code = 3'd0;
            S_F1:    code = 3'd1;
            S_F2:    code = 3'd2;
            S_F3:    code = 3'd3;
            S_E1:    code = 3'd4;
            S_E2:    code = 3'd5;
            S_E3:    code = 3'd6;
            default: code = 3'd7;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/control_wait_timer.sv
// control_wait_timer: stall counter for memory T-states.
//   clk, clr - clock, async active-low reset
//   clear    - synchronous clear (dominates enable)
//   enable   - count one stall cycle
//   expire   - high during the stall cycle that reaches WAIT_MAX stalls
// The count saturates at WAIT_MAX and never wraps.
module control_wait_timer #(
    parameter int WAIT_MAX = 15,
    localparam int CW = $clog2(WAIT_MAX + 1)
) (
    input  logic clk,
    input  logic clr,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != CW'(WAIT_MAX))) begin
            count_q <= count_q + 1'b1;
        end
    end

    // count_q holds the stalls already taken, so the current stall is
    // number count_q+1.
    assign expire = enable && (count_q >= CW'(WAIT_MAX - 1));

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute sequencer for the bus computer.
//   clk, clr           - clock, async active-low reset
//   inst               - opcode field from IR
//   done               - memory ready, ends a memory T-state
//   prgm               - program-mode request (honoured at F1 and HALT)
//   prgm_src/prgm_dst  - manual bus source / destination index
//   prgm_oe/prgm_we    - manual strobes
//   oe, we             - one-hot (or zero) bus enables
//   alu_op, pc_inc     - ALU function, PC increment strobe
//   halted, err        - HALT indicator, sticky error
//   tstate             - debug state code
//
// state | meaning
// IDLE  | after reset, F1 next clock
// F1    | OE PC, WE MAR; instruction boundary, PRGM checked here
// F2    | OE MEM, WE IR; memory T-state
// F3    | PC_INC; opcode latched and decoded
// E1-E3 | execute T-states (E2 is always a memory T-state)
// HALT  | outputs idle, HALTED=1
// PRG   | bus strobes from manual switches
module control_sequencer
    import control_pkg::*;
#(
    parameter int NREG     = 8,
    parameter int OPW      = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [OPW-1:0]          inst,
    input  logic                    done,
    input  logic                    prgm,
    input  logic [$clog2(NREG)-1:0] prgm_src,
    input  logic [$clog2(NREG)-1:0] prgm_dst,
    input  logic                    prgm_oe,
    input  logic                    prgm_we,
    output logic [NREG-1:0]         oe,
    output logic [NREG-1:0]         we,
    output logic [1:0]              alu_op,
    output logic                    pc_inc,
    output logic                    halted,
    output logic                    err,
    output logic [2:0]              tstate
);

    state_t         state;
    logic [OPW-1:0] op_q;
    logic           err_q;
    logic           mem_state;
    logic           tmr_expire;
    logic [3:0]     op_lo;
    logic           inst_hi_ok;

    assign op_lo      = op_q[3:0];
    assign inst_hi_ok = ((inst >> 4) == '0);
    assign mem_state  = (state == S_F2) || (state == S_E2);

    // Clearing whenever outside a memory T-state (or on DONE) guarantees
    // a zero count on entry to the next one.
    control_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .clk    (clk),
        .clr    (clr),
        .clear  (!mem_state || done),
        .enable (mem_state && !done),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_IDLE;
            op_q  <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_F1;
                S_F1:   state <= prgm ? S_PRG : S_F2;
                S_F2: begin
                    if (done) begin
                        state <= S_F3;
                    end else if (tmr_expire) begin
                        state <= S_HALT;
                        err_q <= 1'b1;
                    end
                end
                S_F3: begin
                    op_q <= inst;
                    if (!inst_hi_ok) begin
                        state <= S_HALT;
                        err_q <= 1'b1;
                    end else begin
                        case (inst[3:0])
                            OP_NOP: state <= S_F1;
                            OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_OUT: state <= S_E1;
                            OP_HLT: state <= S_HALT;
                            default: begin
                                state <= S_HALT;
                                err_q <= 1'b1;
                            end
                        endcase
                    end
                end
                S_E1: state <= (op_lo == OP_OUT) ? S_F1 : S_E2;
                S_E2: begin
                    if (done) begin
                        state <= ((op_lo == OP_ADD) || (op_lo == OP_SUB)) ? S_E3 : S_F1;
                    end else if (tmr_expire) begin
                        state <= S_HALT;
                        err_q <= 1'b1;
                    end
                end
                S_E3:   state <= S_F1;
                S_HALT: if (prgm) state <= S_PRG;
                S_PRG: begin
                    if (!prgm) begin
                        state <= S_F1;
                        err_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        oe     = '0;
        we     = '0;
        alu_op = ALU_PASS;
        pc_inc = 1'b0;
        halted = 1'b0;
        case (state)
            S_F1: begin
                oe[AG_PC]  = 1'b1;
                we[AG_MAR] = 1'b1;
            end
            S_F2: begin
                oe[AG_MEM] = 1'b1;
                we[AG_IR]  = 1'b1;
            end
            S_F3: pc_inc = 1'b1;
            S_E1: begin
                if (op_lo == OP_OUT) begin
                    oe[AG_ACC] = 1'b1;
                    we[AG_OR]  = 1'b1;
                end else begin
                    oe[AG_IR]  = 1'b1;
                    we[AG_MAR] = 1'b1;
                end
            end
            S_E2: begin
                if (op_lo == OP_STA) begin
                    oe[AG_ACC] = 1'b1;
                    we[AG_MEM] = 1'b1;
                end else if (op_lo == OP_LDA) begin
                    oe[AG_MEM] = 1'b1;
                    we[AG_ACC] = 1'b1;
                end else begin
                    oe[AG_MEM]  = 1'b1;
                    we[AG_BREG] = 1'b1;
                end
            end
            S_E3: begin
                oe[AG_ALU] = 1'b1;
                we[AG_ACC] = 1'b1;
                alu_op     = (op_lo == OP_SUB) ? ALU_SUB : ALU_ADD;
            end
            S_HALT: halted = 1'b1;
            S_PRG: begin
                // Indices at or above NREG match no bit and leave the bus idle.
                for (int i = 0; i < NREG; i++) begin
                    oe[i] = prgm_oe && (int'(prgm_src) == i);
                    we[i] = prgm_we && (int'(prgm_dst) == i);
                end
            end
            default: ;
        endcase
    end

    assign err    = err_q;
    assign tstate = tstate_code(state);

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] inst;
    logic       done;
    logic       prgm;
    logic [2:0] prgm_src;
    logic [2:0] prgm_dst;
    logic       prgm_oe;
    logic       prgm_we;
    logic [7:0] oe;
    logic [7:0] we;
    logic [1:0] alu_op;
    logic       pc_inc;
    logic       halted;
    logic       err;
    logic [2:0] tstate;

    int n_cmp = 0;
    int n_bad = 0;

    control_sequencer #(.NREG(8), .OPW(4), .WAIT_MAX(15)) dut (
        .clk      (clk),
        .clr      (clr),
        .inst     (inst),
        .done     (done),
        .prgm     (prgm),
        .prgm_src (prgm_src),
        .prgm_dst (prgm_dst),
        .prgm_oe  (prgm_oe),
        .prgm_we  (prgm_we),
        .oe       (oe),
        .we       (we),
        .alu_op   (alu_op),
        .pc_inc   (pc_inc),
        .halted   (halted),
        .err      (err),
        .tstate   (tstate)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [2:0] ts,
                           input logic [7:0] e_oe, input logic [7:0] e_we);
        chk({tag, ".ts"}, 32'(tstate), 32'(ts));
        chk({tag, ".oe"}, 32'(oe), 32'(e_oe));
        chk({tag, ".we"}, 32'(we), 32'(e_we));
    endtask

    task automatic chk_flags(input string tag, input logic e_pc, input logic [1:0] e_alu,
                             input logic e_halt, input logic e_err);
        chk({tag, ".pc_inc"}, 32'(pc_inc), 32'(e_pc));
        chk({tag, ".alu"},    32'(alu_op), 32'(e_alu));
        chk({tag, ".halted"}, 32'(halted), 32'(e_halt));
        chk({tag, ".err"},    32'(err),    32'(e_err));
    endtask

    initial begin
        clr = 1'b0; inst = 4'h0; done = 1'b1; prgm = 1'b0;
        prgm_src = 3'd0; prgm_dst = 3'd0; prgm_oe = 1'b0; prgm_we = 1'b0;

        // Reset
        #3;
        chk_bus("rst", 3'd0, 8'h00, 8'h00);
        chk_flags("rst", 1'b0, 2'b00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
        chk_bus("idle", 3'd0, 8'h00, 8'h00);

        // LDA, DONE high: 5 cycles
        inst = 4'h1;
        tick(); chk_bus("lda.f1", 3'd1, 8'h01, 8'h08);
        tick(); chk_bus("lda.f2", 3'd2, 8'h10, 8'h40);
        tick(); chk_bus("lda.f3", 3'd3, 8'h00, 8'h00);
        chk_flags("lda.f3", 1'b1, 2'b00, 1'b0, 1'b0);
        tick(); chk_bus("lda.e1", 3'd4, 8'h40, 8'h08);
        tick(); chk_bus("lda.e2", 3'd5, 8'h10, 8'h02);
        tick(); chk_bus("lda.next", 3'd1, 8'h01, 8'h08);

        // ADD with 3 stalls in F2 and E2: 12 cycles
        inst = 4'h2; done = 1'b0;
        tick(); chk_bus("add.f2", 3'd2, 8'h10, 8'h40);
        for (int i = 0; i < 3; i++) begin
            tick(); chk_bus("add.f2stall", 3'd2, 8'h10, 8'h40);
        end
        done = 1'b1;
        tick(); chk_bus("add.f3", 3'd3, 8'h00, 8'h00);
        tick(); chk_bus("add.e1", 3'd4, 8'h40, 8'h08);
        done = 1'b0;
        tick(); chk_bus("add.e2", 3'd5, 8'h10, 8'h04);
        for (int i = 0; i < 3; i++) begin
            tick(); chk_bus("add.e2stall", 3'd5, 8'h10, 8'h04);
        end
        done = 1'b1;
        tick(); chk_bus("add.e3", 3'd6, 8'h80, 8'h02);
        chk_flags("add.e3", 1'b0, 2'b01, 1'b0, 1'b0);
        tick(); chk_bus("add.next", 3'd1, 8'h01, 8'h08);

        // OUT then NOP
        inst = 4'h5;
        tick(); tick(); tick();
        chk_bus("out.e1", 3'd4, 8'h02, 8'h20);
        inst = 4'h0;
        tick(); chk_bus("out.next", 3'd1, 8'h01, 8'h08);
        tick(); tick(); chk_bus("nop.f3", 3'd3, 8'h00, 8'h00);
        tick(); chk_bus("nop.next", 3'd1, 8'h01, 8'h08);

        // Timeout in F2 after 15 stall cycles
        done = 1'b0;
        tick(); chk_bus("to.f2", 3'd2, 8'h10, 8'h40);
        for (int i = 0; i < 14; i++) begin
            tick(); chk("to.stall.ts", 32'(tstate), 32'd2);
        end
        chk("to.noerr", 32'(err), 32'd0);
        tick(); chk_bus("to.halt", 3'd7, 8'h00, 8'h00);
        chk_flags("to.halt", 1'b0, 2'b00, 1'b1, 1'b1);
        tick(); chk("to.stay", 32'(halted), 32'd1);

        // Leave HALT through PRG; ERR clears on exit
        prgm = 1'b1; done = 1'b1;
        tick(); chk_flags("to.prg", 1'b0, 2'b00, 1'b0, 1'b1);
        prgm = 1'b0;
        tick(); chk_bus("to.f1", 3'd1, 8'h01, 8'h08);
        chk("to.errclr", 32'(err), 32'd0);

        // Illegal opcode 8
        inst = 4'h8;
        tick(); tick(); tick();
        chk_bus("ill.halt", 3'd7, 8'h00, 8'h00);
        chk_flags("ill.halt", 1'b0, 2'b00, 1'b1, 1'b1);
        prgm = 1'b1;
        tick(); chk("ill.prg.halted", 32'(halted), 32'd0);
        prgm_src = 3'd1; prgm_dst = 3'd5; prgm_oe = 1'b1; prgm_we = 1'b1;
        #1 chk_bus("prg.both", 3'd7, 8'h02, 8'h20);
        chk("prg.err", 32'(err), 32'd1);
        prgm_oe = 1'b0; prgm_dst = 3'd7;
        #1 chk_bus("prg.we_only", 3'd7, 8'h00, 8'h80);
        prgm_we = 1'b0;
        prgm = 1'b0;
        tick(); chk_bus("prg.exit", 3'd1, 8'h01, 8'h08);
        chk("prg.errclr", 32'(err), 32'd0);

        // HLT opcode: halt without error
        inst = 4'hF;
        tick(); tick(); tick();
        chk_flags("hlt", 1'b0, 2'b00, 1'b1, 1'b0);
        prgm = 1'b1; tick();
        prgm = 1'b0; tick();
        chk_bus("hlt.f1", 3'd1, 8'h01, 8'h08);

        // STA with PRGM raised in E1
        inst = 4'h4;
        tick(); tick(); tick();
        chk_bus("sta.e1", 3'd4, 8'h40, 8'h08);
        prgm = 1'b1;
        tick(); chk_bus("sta.e2", 3'd5, 8'h02, 8'h10);
        tick(); chk_bus("sta.f1", 3'd1, 8'h01, 8'h08);
        tick(); chk("sta.prg", 32'(tstate), 32'd7);
        chk("sta.prg.halted", 32'(halted), 32'd0);
        prgm = 1'b0;
        tick(); chk("sta.exit", 32'(tstate), 32'd1);

        // SUB aborted by reset in E2
        inst = 4'h3;
        tick(); tick(); tick(); tick();
        chk_bus("sub.e2", 3'd5, 8'h10, 8'h04);
        #2 clr = 1'b0;
        #1 chk_bus("sub.rst", 3'd0, 8'h00, 8'h00);
        chk_flags("sub.rst", 1'b0, 2'b00, 1'b0, 1'b0);
        tick(); chk("sub.rst.hold", 32'(tstate), 32'd0);
        clr = 1'b1;
        #1 chk("sub.idle", 32'(tstate), 32'd0);
        tick(); chk_bus("sub.f1", 3'd1, 8'h01, 8'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised instruction sequencer for the bus-based accumulator computer; successor to the fixed control unit. It steps fetch/decode/execute T-states and drives one-hot output-enable and write-enable vectors for every bus agent. Memory accesses stall on a DONE handshake with a timeout, and a manual program mode hands the bus strobes to external switches. It sits between the instruction register, the EEPROM, and the shared 8-bit bus.

## Interface
- NREG, 8: number of bus agents (≥8). Indices are fixed by the package: PC=0, ACC=1, BREG=2, MAR=3, MEM=4, OR=5, IR=6, ALU=7; extras are spare.
- OPW, 4: opcode width. Only the low 4 bits are decoded; nonzero upper bits mean an illegal opcode.
- WAIT_MAX, 15: maximum stall cycles per memory T-state (≥1).
- CLK  in  1  system clock, rising edge.
- CLR  in  1  asynchronous, active-low reset.
- INST  in  OPW  opcode field from IR.
- DONE  in  1  memory ready; sampled high ends a MEM T-state.
- PRGM  in  1  program-mode request.
- PRGM_SRC / PRGM_DST  in  $clog2(NREG)  manual source and destination index.
- PRGM_OE / PRGM_WE  in  1  manual strobes.
- OE  out  NREG  one-hot or zero bus-source enable.
- WE  out  NREG  one-hot or zero bus-sink write enable.
- ALU_OP  out  2  00 pass, 01 add, 10 sub.
- PC_INC  out  1  PC increment strobe.
- HALTED  out  1  high in HALT.
- ERR  out  1  sticky error flag.
- TSTATE  out  3  debug state code.

## Operation
- States: IDLE, F1, F2, F3, E1, E2, E3, HALT, PRG.
- Outputs are Moore-decoded from the state and the latched opcode (`op_q`).
- IDLE: all outputs 0. Goes to F1 on the first clock after reset release.
- F1: OE[PC], WE[MAR]. If PRGM=1, go to PRG instead; F1 is the only instruction boundary.
- F2: OE[MEM], WE[IR]. Memory T-state.
- F3: PC_INC=1. `op_q` ← INST at the end of F3.
- Opcodes and their execute T-states (a T-state with no action does not exist):
  - 0 NOP: none.
  - 1 LDA: E1 OE[IR],WE[MAR]; E2 OE[MEM],WE[ACC].
  - 2 ADD: E1 OE[IR],WE[MAR]; E2 OE[MEM],WE[BREG]; E3 OE[ALU],WE[ACC],ALU_OP=01.
  - 3 SUB: same as ADD with ALU_OP=10.
  - 4 STA: E1 OE[IR],WE[MAR]; E2 OE[ACC],WE[MEM].
  - 5 OUT: E1 OE[ACC],WE[OR].
  - F HLT: go to HALT.
  - Any other value: set ERR, go to HALT.
- After the last execute T-state, go to F1.
- Memory T-states are any state with OE[MEM] or WE[MEM] set:
  - The state and all outputs hold until DONE is sampled high.
  - The wait counter clears on entry to each memory T-state.
  - If WAIT_MAX cycles pass without DONE: set ERR, go to HALT.
- HALT: outputs 0, HALTED=1. Leaves only on reset, or on PRGM=1 (goes to PRG).
- PRG:
  - OE = PRGM_OE ? onehot(PRGM_SRC) : 0.
  - WE = PRGM_WE ? onehot(PRGM_DST) : 0.
  - An out-of-range index gives 0.
  - PRGM=0 goes to F1 and clears ERR.

## Timing
- Reset: state=IDLE, `op_q`=0, ERR=0, wait counter=0. All outputs are 0 and TSTATE=0 while CLR is low, independent of CLK.
- Reset asserted mid-instruction aborts immediately with no partial strobes.
- Cycles per instruction with DONE held high: NOP 3, OUT 4, LDA 5, STA 5, ADD 6, SUB 6. Each stall cycle adds 1.
- DONE already high on entry to a memory T-state means no stall.
- PRGM asserted mid-instruction is ignored until the next F1.
- PRGM and timeout in the same cycle: timeout wins (go to HALT).
- The wait counter saturates and never wraps.
- At most one OE bit is set in any cycle.

## Structure
- Package `control_pkg`: state enum, agent index constants, opcode constants, ALU_OP codes, TSTATE encoding.
- Sub-module `control_wait_timer`: clear/enable/expire counter, width $clog2(WAIT_MAX+1).

## Test plan
- Reset, then LDA (INST=1) with DONE=1 → 5 cycles. E2 shows OE=0x10, WE=0x02, then returns to F1.
- ADD with DONE delayed 3 cycles in F2 and E2 → 12 cycles total. E3 shows OE=0x80, WE=0x02, ALU_OP=01.
- DONE held low in F2 with WAIT_MAX=15 → ERR=1 and HALTED=1 after 15 stall cycles; all outputs 0.
- INST=8 → ERR=1, HALT after F3. PRGM=1 → PRG; PRGM_SRC=1, PRGM_DST=5, both strobes set → OE=0x02, WE=0x20. PRGM=0 → ERR clears, F1.
- PRGM=1 raised during E1 of STA → STA completes and PRG is entered at the next F1.
- CLR low during E2 of SUB → outputs 0 asynchronously. After release: IDLE, then F1.
